cfg_serializer: RTL and testbench
=================================

Name: cfg_serializer

Overview:
Parametrised successor to the fixed 8-bit UART TX serializer.
- Converts a parallel word of run-time-selectable length (1..DATA_WIDTH bits) into a serial bit stream.
- Bit order (LSB- or MSB-first) is selected at load time.
- Uses a valid/ready load handshake, stall-on-ser_enable-low, synchronous abort and a registered single-cycle done pulse.
- Sits between the TX FIFO/data-sync stage and the UART TX framing FSM/output mux, which drives ser_enable.

Parameters:
DATA_WIDTH, 8, maximum word width in bits (>=2).
CNT_W, $clog2(DATA_WIDTH), bit-index counter width; derived, not overridden.
LEN_W, $clog2(DATA_WIDTH+1), width of cfg_len; derived.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
p_data  in  DATA_WIDTH  parallel word; bits above cfg_len ignored
p_valid  in  1  load request
p_ready  out  1  high when a load is accepted this cycle (state IDLE)
cfg_len  in  LEN_W  bits per word, sampled at load; 0 or >DATA_WIDTH means DATA_WIDTH
cfg_msb_first  in  1  sampled at load; 1 = MSB-first, 0 = LSB-first
ser_enable  in  1  advance one bit per cycle while high
ser_abort  in  1  synchronous abort to IDLE
ser_data  out  1  current serial bit
ser_done  out  1  one-cycle pulse after last bit consumed
busy  out  1  high in LOADED/SHIFT

Behaviour:
- Reset (rst low, async): state IDLE, shift register 0, counter 0, ser_done 0, ser_data 0, busy 0. p_ready is 1 once rst is released.
- States:
  - IDLE: p_ready=1. On p_valid: capture the word, latch len_q and msb_q, counter=0, go to LOADED. ser_enable is ignored in IDLE.
  - LOADED: ser_data already shows the first bit. On ser_enable go to SHIFT, consuming bit 0 in that cycle.
  - SHIFT: on each ser_enable cycle, shift by one and increment the counter. ser_enable low holds the register and counter (stall, no reset; this differs from the old block).
- Data alignment and shifting:
  - LSB-first: register = p_data with bits >= len zeroed. ser_data = reg[0]; shift right, fill 0.
  - MSB-first: register = masked p_data << (DATA_WIDTH-len). ser_data = reg[DATA_WIDTH-1]; shift left, fill 0.
- End of word: when ser_enable is high and counter == len_q-1 (last bit consumed):
  - Next cycle: state IDLE, ser_done=1 for exactly one cycle, register cleared, ser_data 0.
  - p_ready=1 in that same cycle, so back-to-back loads give a one-cycle gap between the last bit of word N and the first bit of word N+1.
- Latency and length:
  - Load to first bit valid on ser_data: 1 cycle.
  - Word of length L with ser_enable held high: ser_done asserts L+1 cycles after the load cycle.
  - len=1: the first ser_enable cycle is also the last bit.
- ser_abort: highest priority in every state. Next cycle: IDLE, register and counter cleared, no ser_done. Load and abort in the same cycle: abort wins and the load is dropped (p_ready still reads 1, so the upstream FIFO must gate its pop with !ser_abort).
- cfg_len and cfg_msb_first changes while busy have no effect.
- Counter never wraps. Its range is 0..len_q-1 and it saturates by returning to IDLE.

Optional Feature:
Macro SERIALIZER_PARITY_EN.
- When defined: adds input par_type (0 even, 1 odd) sampled at load, and output par_bit. par_bit = XOR of the len valid bits, inverted if odd. It is registered at load and stable until the next load; reset value 0.
- When undefined: neither port exists and no parity logic is built. The framing FSM uses its own parity_calc block.

Decomposition:
- Package cfg_serializer_pkg: state enum ser_state_e {IDLE, LOADED, SHIFT}; a function eff_len(cfg_len) mapping 0 or out-of-range values to DATA_WIDTH; a function len_mask(len).
- One sub-module, cfg_serializer_cnt: bit counter with enable, clear, load, and terminal flag (== len_q-1).
- Shift register and FSM stay in the top level.

Test Plan:
- Reset, then p_data=0xA5, len=8, LSB-first, ser_enable held high -> ser_data 1,0,1,0,0,1,0,1; ser_done single pulse 9 cycles after load; p_ready high that cycle.
- p_data=0xA5, len=8, MSB-first -> 1,0,1,0,0,1,0,1. Then p_data=0x0D, len=4, MSB-first -> 1,1,0,1; ser_done 5 cycles after load.
- p_data=0xFF, len=3, LSB-first, ser_enable dropped for 4 cycles after bit 1 -> exactly 3 ones with ser_data held during the stall; ser_done after the third enabled cycle; no extra bits.
- ser_abort asserted after 2 bits of 0x3C -> IDLE next cycle, ser_data 0, busy 0, no ser_done. Next load 0x81 serialises cleanly.
- Back-to-back 0x12 then 0x34 (len=8, p_valid held high) -> second word accepted in the ser_done cycle; its first bit appears 1 cycle later.
- SERIALIZER_PARITY_EN: 0xA5, par_type=0 -> par_bit=0; 0x07, par_type=1 -> par_bit=0; 0x07, len=2, par_type=0 -> par_bit=0. Async rst mid-SHIFT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cfg_serializer_pkg.sv
// Shared types and helpers for the configurable-length serializer.
package cfg_serializer_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFT
  } ser_state_e;

  // A length of 0, or one beyond the word width, means "use the full word".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

  function automatic logic [MAX_W-1:0] len_mask(input int unsigned len);
    return (len >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << len) - MAX_W'(1));
  endfunction

endpackage

// File: rtl/cfg_serializer_cnt.sv
// Bit-index counter for cfg_serializer; holds the latched word length and
// flags the last bit of the word.
module cfg_serializer_cnt #(
  parameter int CNT_W = 3,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_term
);

  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_len_q <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_len_q <= i_len;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_term = (LEN_W'(r_cnt) == (r_len_q - LEN_W'(1)));

endmodule

// File: rtl/cfg_serializer.sv
// Parallel-to-serial converter with run-time word length and bit order.
// Define SERIALIZER_PARITY_EN to add the par_type input and par_bit output.
module cfg_serializer
  import cfg_serializer_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(DATA_WIDTH),
  localparam int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  cfg_msb_first,
  input  logic                  ser_enable,
  input  logic                  ser_abort,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy
`ifdef SERIALIZER_PARITY_EN
  ,
  input  logic                  par_type,
  output logic                  par_bit
`endif
);

  ser_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_msb;
  logic                  r_done;

  logic [LEN_W-1:0]      w_len;
  logic [LEN_W-1:0]      w_shamt;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_masked;
  logic [DATA_WIDTH-1:0] w_aligned;
  logic                  w_active;
  logic                  w_load;
  logic                  w_adv;
  logic                  w_term;
  logic                  w_clr;

  // MSB-first words are left-justified so the first bit always sits at the top.
  assign w_len     = LEN_W'(eff_len(32'(cfg_len), DATA_WIDTH));
  assign w_mask    = DATA_WIDTH'(len_mask(32'(w_len)));
  assign w_masked  = p_data & w_mask;
  assign w_shamt   = LEN_W'(DATA_WIDTH) - w_len;
  assign w_aligned = cfg_msb_first ? (w_masked << w_shamt) : w_masked;

  assign w_active = (r_state != IDLE);
  assign w_load   = (r_state == IDLE) && p_valid && !ser_abort;
  assign w_adv    = w_active && ser_enable && !ser_abort;
  assign w_clr    = ser_abort || (w_adv && w_term);

  cfg_serializer_cnt #(
    .CNT_W(CNT_W),
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_load(w_load),
    .i_en  (w_adv && !w_term),
    .i_len (w_len),
    .o_term(w_term)
  );

  // Abort outranks everything; LOADED and SHIFT consume bits identically.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_msb   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ser_abort) begin
        r_state <= IDLE;
        r_shift <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (p_valid) begin
              r_shift <= w_aligned;
              r_msb   <= cfg_msb_first;
              r_state <= LOADED;
            end
          end
          LOADED, SHIFT: begin
            if (ser_enable) begin
              if (w_term) begin
                r_state <= IDLE;
                r_shift <= '0;
                r_done  <= 1'b1;
              end else begin
                r_state <= SHIFT;
                r_shift <= r_msb ? (r_shift << 1) : (r_shift >> 1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef SERIALIZER_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= (^w_masked) ^ par_type;
    end
  end

  assign par_bit = r_par;
`endif

  assign p_ready  = (r_state == IDLE);
  assign busy     = w_active;
  assign ser_data = r_msb ? r_shift[DATA_WIDTH-1] : r_shift[0];
  assign ser_done = r_done;

endmodule

// File: tb/tb_cfg_serializer.sv
// Self-checking bench for cfg_serializer: vector table, directed corner cases
// and randomized traffic checked against a bit-queue reference model.
module tb_cfg_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       p_valid;
  logic       p_ready;
  logic [3:0] cfg_len;
  logic       cfg_msb_first;
  logic       ser_enable;
  logic       ser_abort;
  logic       ser_data;
  logic       ser_done;
  logic       busy;
`ifdef SERIALIZER_PARITY_EN
  logic       par_type;
  logic       par_bit;
`endif

  int total = 0;
  int bad   = 0;

  bit mBits[$];
  bit mBusy;
  bit mDone;
  bit mPar;

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic       msb;
    logic [7:0] stream;
    int         nbits;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  cfg_serializer #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .p_data       (p_data),
    .p_valid      (p_valid),
    .p_ready      (p_ready),
    .cfg_len      (cfg_len),
    .cfg_msb_first(cfg_msb_first),
    .ser_enable   (ser_enable),
    .ser_abort    (ser_abort),
    .ser_data     (ser_data),
    .ser_done     (ser_done),
    .busy         (busy)
`ifdef SERIALIZER_PARITY_EN
    ,
    .par_type     (par_type),
    .par_bit      (par_bit)
`endif
  );

  task automatic checkOutput(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkWord(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int effLen(input logic [3:0] len);
    return ((len == 4'd0) || (len > 4'd8)) ? 8 : int'(len);
  endfunction

  function automatic void modelReset();
    mBits.delete();
    mBusy = 1'b0;
    mDone = 1'b0;
    mPar  = 1'b0;
  endfunction

  task automatic checkModel();
    checkOutput("m_ser_data", ser_data, (mBusy && mBits.size() > 0) ? mBits[0] : 1'b0);
    checkOutput("m_busy", busy, mBusy);
    checkOutput("m_p_ready", p_ready, !mBusy);
    checkOutput("m_ser_done", ser_done, mDone);
`ifdef SERIALIZER_PARITY_EN
    checkOutput("m_par_bit", par_bit, mPar);
`endif
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] len,
                               input logic msb, input logic en, input logic ab);
    p_valid       = v;
    p_data        = d;
    cfg_len       = len;
    cfg_msb_first = msb;
    ser_enable    = en;
    ser_abort     = ab;
  endtask

  // Reference: a loaded word is just a queue of its bits in transmit order.
  task automatic modelStep();
    int L;
    int ones;
    mDone = 1'b0;
    if (ser_abort) begin
      mBits.delete();
      mBusy = 1'b0;
    end else if (!mBusy) begin
      if (p_valid) begin
        L = effLen(cfg_len);
        ones = 0;
        for (int i = 0; i < L; i++) begin
          mBits.push_back(cfg_msb_first ? p_data[L-1-i] : p_data[i]);
          ones += int'(p_data[i]);
        end
        mBusy = 1'b1;
`ifdef SERIALIZER_PARITY_EN
        mPar = 1'((ones % 2) != 0) ^ par_type;
`endif
      end
    end else if (ser_enable) begin
      void'(mBits.pop_front());
      if (mBits.size() == 0) begin
        mBusy = 1'b0;
        mDone = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic [3:0] len,
                      input logic msb, input logic en, input logic ab);
    checkModel();
    applyStimulus(v, d, len, msb, en, ab);
    modelStep();
    @(negedge clk);
  endtask

  task automatic runVector(input vec_t vc);
    logic [7:0] stream;
    tick(1'b1, vc.data, vc.len, vc.msb, 1'b0, 1'b0);
    stream = '0;
    for (int i = 0; i < vc.nbits; i++) begin
      stream = stream | (8'(ser_data) << i);
      tick(1'b0, vc.data, vc.len, vc.msb, 1'b1, 1'b0);
    end
    checkOutput("vec_done_at_len_plus_1", ser_done, 1'b1);
    checkOutput("vec_ready_at_done", p_ready, 1'b1);
    checkWord("vec_stream", int'(stream), int'(vc.stream));
    tick(1'b0, vc.data, vc.len, vc.msb, 1'b0, 1'b0);
    checkOutput("vec_done_single_pulse", ser_done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ones;
    int c;
    bit found;

    vecs[0] = '{8'hA5, 4'd8,  1'b0, 8'hA5, 8};
    vecs[1] = '{8'hA5, 4'd8,  1'b1, 8'hA5, 8};
    vecs[2] = '{8'h0D, 4'd4,  1'b1, 8'h0B, 4};
    vecs[3] = '{8'h81, 4'd8,  1'b0, 8'h81, 8};
    vecs[4] = '{8'h12, 4'd8,  1'b1, 8'h48, 8};
    vecs[5] = '{8'h3C, 4'd0,  1'b0, 8'h3C, 8};
    vecs[6] = '{8'h02, 4'd1,  1'b0, 8'h00, 1};
    vecs[7] = '{8'h01, 4'd1,  1'b1, 8'h01, 1};
    vecs[8] = '{8'hC3, 4'd12, 1'b1, 8'hC3, 8};
    vecs[9] = '{8'hF3, 4'd5,  1'b1, 8'h19, 5};

`ifdef SERIALIZER_PARITY_EN
    par_type = 1'b0;
`endif
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 4'd8, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_ser_data", ser_data, 1'b0);
    checkOutput("reset_ser_done", ser_done, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    rst = 1'b1;
    modelReset();
    tick(1'b0, 8'h00, 4'd8, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 10; k++) runVector(vecs[k]);

    // Stall in the middle of a 3-bit word.
    tick(1'b1, 8'hFF, 4'd3, 1'b0, 1'b0, 1'b0);
    ones = int'(ser_data);
    tick(1'b0, 8'hFF, 4'd3, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 4; s++) begin
      checkOutput("stall_hold_data", ser_data, 1'b1);
      checkOutput("stall_no_done", ser_done, 1'b0);
      tick(1'b0, 8'hFF, 4'd3, 1'b0, 1'b0, 1'b0);
    end
    ones += int'(ser_data);
    tick(1'b0, 8'hFF, 4'd3, 1'b0, 1'b1, 1'b0);
    ones += int'(ser_data);
    tick(1'b0, 8'hFF, 4'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("stall_done", ser_done, 1'b1);
    checkWord("stall_ones", ones, 3);
    tick(1'b0, 8'hFF, 4'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("stall_no_extra_bits", ser_data, 1'b0);
    checkOutput("stall_idle", busy, 1'b0);

    // Abort after two bits, then a clean word.
    tick(1'b1, 8'h3C, 4'd8, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h3C, 4'd8, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 8'h3C, 4'd8, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 8'h3C, 4'd8, 1'b0, 1'b1, 1'b1);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_ser_data", ser_data, 1'b0);
    checkOutput("abort_no_done", ser_done, 1'b0);
    tick(1'b0, 8'h00, 4'd8, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_no_late_done", ser_done, 1'b0);
    runVector(vecs[3]);
    tick(1'b1, 8'h55, 4'd8, 1'b0, 1'b1, 1'b1);
    checkOutput("load_abort_dropped", busy, 1'b0);

    // Back-to-back words with p_valid held high.
    tick(1'b1, 8'h12, 4'd8, 1'b0, 1'b1, 1'b0);
    found = 1'b0;
    c = 0;
    while (c < 20 && !found) begin
      if (ser_done) found = 1'b1;
      else begin
        tick(1'b1, 8'h34, 4'd8, 1'b0, 1'b1, 1'b0);
        c++;
      end
    end
    checkOutput("b2b_done_seen", found, 1'b1);
    checkWord("b2b_done_latency", c + 1, 9);
    checkOutput("b2b_ready_at_done", p_ready, 1'b1);
    tick(1'b1, 8'h34, 4'd8, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_second_busy", busy, 1'b1);
    checkOutput("b2b_second_first_bit", ser_data, 1'b0);
    for (int i = 0; i < 9; i++) tick(1'b0, 8'h00, 4'd8, 1'b0, 1'b1, 1'b0);

`ifdef SERIALIZER_PARITY_EN
    par_type = 1'b0;
    tick(1'b1, 8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("par_a5_even", par_bit, 1'b0);
    tick(1'b0, 8'h00, 4'd8, 1'b0, 1'b0, 1'b1);
    par_type = 1'b1;
    tick(1'b1, 8'h07, 4'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("par_07_odd", par_bit, 1'b0);
    tick(1'b0, 8'h00, 4'd8, 1'b0, 1'b0, 1'b1);
    par_type = 1'b0;
    tick(1'b1, 8'h07, 4'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("par_07_len2_even", par_bit, 1'b0);
    tick(1'b0, 8'h00, 4'd8, 1'b0, 1'b0, 1'b1);
    par_type = 1'b1;
    tick(1'b1, 8'h07, 4'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("par_07_len2_odd", par_bit, 1'b1);
    tick(1'b0, 8'h00, 4'd8, 1'b0, 1'b0, 1'b1);
`endif

    // Asynchronous reset in the middle of a word.
    tick(1'b1, 8'hF0, 4'd8, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 8'hF0, 4'd8, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 8'hF0, 4'd8, 1'b1, 1'b1, 1'b0);
    checkOutput("pre_rst_busy", busy, 1'b1);
    applyStimulus(1'b0, 8'h00, 4'd8, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_ser_data", ser_data, 1'b0);
    checkOutput("async_rst_busy", busy, 1'b0);
    checkOutput("async_rst_done", ser_done, 1'b0);
`ifdef SERIALIZER_PARITY_EN
    checkOutput("async_rst_par", par_bit, 1'b0);
`endif
    modelReset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the reference model.
    for (int r = 0; r < 600; r++) begin
`ifdef SERIALIZER_PARITY_EN
      par_type = 1'($urandom);
`endif
      tick(1'($urandom_range(0, 2) == 0), 8'($urandom), 4'($urandom_range(0, 15)),
           1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
    end
    tick(1'b0, 8'h00, 4'd8, 1'b0, 1'b0, 1'b0);
    checkModel();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
